uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 114 +++++++++++
 tb/tb_uart_rx_sampler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART RX oversampling edge/bit counters with 2-of-3 majority-vote sampler
// Optional input synchronizer: define UART_RX_SYNC_EN to pass RX_IN through two reset-to-1 flops.
module uart_rx_sampler #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Edge_EN_CNT,
    input  logic                  Bit_EN_CNT,
    input  logic                  Data_Sample_EN,
    output logic [PRESCALE_W-1:0] Edge_Count,
    output logic [BCW-1:0]        Bit_Counter,
    output logic                  Done,
    output logic                  Sampled_Bit,
    output logic                  Sampling_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    localparam logic [BCW-1:0]        BIT_LAST = BCW'(DATA_WIDTH - 1);

    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] half;
    logic                  rx_line;
    logic                  sample_on;
    logic                  s0;
    logic                  s1;

    // Unsupported ratios fall back to 8x oversampling so the counter can never lock up.
    always_comb begin
        p_eff = PRESCALE_W'(8);
        if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32)) begin
            p_eff = Prescale;
        end
    end

    assign p_last    = p_eff - ONE;
    assign half      = p_eff >> 1;
    // >= rather than == so a mid-bit drop of Prescale still terminates the bit.
    assign Done      = Edge_EN_CNT && (Edge_Count >= p_last);
    assign sample_on = Edge_EN_CNT && Data_Sample_EN;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop metastability guard on the asynchronous serial line; idles high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = RX_IN;
`endif

    // Oversample tick counter: restarts whenever disabled and at the last tick of each bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Edge_Count <= '0;
        end else if (!Edge_EN_CNT || Done) begin
            Edge_Count <= '0;
        end else begin
            Edge_Count <= Edge_Count + ONE;
        end
    end

    // Data bit index: advances at the end of each bit period, disable has priority.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Bit_Counter <= '0;
        end else if (!Bit_EN_CNT) begin
            Bit_Counter <= '0;
        end else if (Done) begin
            Bit_Counter <= (Bit_Counter == BIT_LAST) ? '0 : Bit_Counter + BCW'(1);
        end
    end

    // Capture two samples before mid-bit; the third (mid-bit) sample feeds the vote directly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0            <= 1'b1;
            s1            <= 1'b1;
            Sampled_Bit   <= 1'b1;
            Sampling_done <= 1'b0;
        end else begin
            Sampling_done <= 1'b0;
            if (!sample_on) begin
                s0 <= 1'b1;
                s1 <= 1'b1;
            end else begin
                if (Edge_Count == half - TWO) begin
                    s0 <= rx_line;
                end
                if (Edge_Count == half - ONE) begin
                    s1 <= rx_line;
                end
                if (Edge_Count == half) begin
                    Sampled_Bit   <= (s0 & s1) | (s0 & rx_line) | (s1 & rx_line);
                    Sampling_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler (with or without UART_RX_SYNC_EN)
module tb_uart_rx_sampler;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       Edge_EN_CNT = 1'b0;
    logic       Bit_EN_CNT = 1'b0;
    logic       Data_Sample_EN = 1'b0;
    logic [5:0] Edge_Count;
    logic [2:0] Bit_Counter;
    logic       Done;
    logic       Sampled_Bit;
    logic       Sampling_done;

    int total = 0;
    int bad = 0;

    uart_rx_sampler dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .Edge_EN_CNT(Edge_EN_CNT),
        .Bit_EN_CNT(Bit_EN_CNT),
        .Data_Sample_EN(Data_Sample_EN),
        .Edge_Count(Edge_Count),
        .Bit_Counter(Bit_Counter),
        .Done(Done),
        .Sampled_Bit(Sampled_Bit),
        .Sampling_done(Sampling_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_p(input int pre);
        if (pre == 8 || pre == 16 || pre == 32) return pre;
        return 8;
    endfunction

    // ---------------- behavioural model ----------------
    int   m_ec = 0;
    int   m_bc = 0;
    logic m_sb = 1'b1;
    logic m_sd = 1'b0;
    logic tick_line [64];
    bit   tick_ok [64];
`ifdef UART_RX_SYNC_EN
    logic m_d1 = 1'b1;
    logic m_d2 = 1'b1;
`endif

    always @(posedge CLK or negedge RST) begin
        int   p;
        logic line;
        bit   dn;
        int   ones;
        if (!RST) begin
            m_ec = 0;
            m_bc = 0;
            m_sb = 1'b1;
            m_sd = 1'b0;
            for (int i = 0; i < 64; i++) tick_ok[i] = 0;
`ifdef UART_RX_SYNC_EN
            m_d1 = 1'b1;
            m_d2 = 1'b1;
`endif
        end else begin
            p = eff_p(int'(Prescale));
`ifdef UART_RX_SYNC_EN
            line = m_d2;
`else
            line = RX_IN;
`endif
            dn   = Edge_EN_CNT && (m_ec >= p - 1);
            m_sd = 1'b0;
            if (Edge_EN_CNT && Data_Sample_EN) begin
                tick_line[m_ec] = line;
                tick_ok[m_ec]   = 1;
                if (m_ec == p / 2) begin
                    ones = int'(line);
                    ones += tick_ok[p/2-2] ? int'(tick_line[p/2-2]) : 1;
                    ones += tick_ok[p/2-1] ? int'(tick_line[p/2-1]) : 1;
                    m_sb = (ones >= 2);
                    m_sd = 1'b1;
                end
            end else begin
                for (int i = 0; i < 64; i++) tick_ok[i] = 0;
            end
            if (dn) for (int i = 0; i < 64; i++) tick_ok[i] = 0;
            if (!Bit_EN_CNT) m_bc = 0;
            else if (dn) m_bc = (m_bc + 1) % 8;
            m_ec = (!Edge_EN_CNT || dn) ? 0 : m_ec + 1;
`ifdef UART_RX_SYNC_EN
            m_d2 = m_d1;
            m_d1 = RX_IN;
`endif
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge CLK) begin
        int p;
        p = eff_p(int'(Prescale));
        chk("edge_count", int'(Edge_Count), m_ec);
        chk("bit_counter", int'(Bit_Counter), m_bc);
        chk("done", int'(Done), int'(Edge_EN_CNT && (m_ec >= p - 1)));
        chk("sampled_bit", int'(Sampled_Bit), int'(m_sb));
        chk("sampling_done", int'(Sampling_done), int'(m_sd));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One bit period from Edge_Count=0; pat[2:0] is the line value at ticks P/2-2, P/2-1, P/2.
    task automatic run_bit(input int pre, input logic [2:0] pat, input logic sen, input logic ben,
                           output logic [31:0] dm, output int sd_at, output int sd_n);
        int pe;
        int k;
        pe = eff_p(pre);
        dm = '0;
        sd_at = -1;
        sd_n = 0;
        Prescale = 6'(pre);
        Edge_EN_CNT = 1'b1;
        Data_Sample_EN = sen;
        Bit_EN_CNT = ben;
        for (int j = 0; j < pe; j++) begin
            k = j - LAT;
            if (k == pe / 2 - 2) RX_IN = pat[2];
            else if (k == pe / 2 - 1) RX_IN = pat[1];
            else if (k == pe / 2) RX_IN = pat[0];
            else RX_IN = 1'b1;
            @(negedge CLK);
            if (Done) dm[j] = 1'b1;
            if (Sampling_done) begin
                sd_n++;
                sd_at = j;
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] dm;
        int sd_at;
        int sd_n;
        int pulses;

        #12;
        chk("rst_edge_count", int'(Edge_Count), 0);
        chk("rst_bit_counter", int'(Bit_Counter), 0);
        chk("rst_sampled_bit", int'(Sampled_Bit), 1);
        chk("rst_sampling_done", int'(Sampling_done), 0);
        chk("rst_done", int'(Done), 0);
        step();
        RST = 1'b1;
        step();

        // Edge counter alone at P=8: Done only on the last tick of each period.
        for (int b = 0; b < 2; b++) begin
            run_bit(8, 3'b111, 1'b0, 1'b0, dm, sd_at, sd_n);
            chk("p8_done_mask", int'(dm), 32'h80);
            chk("p8_no_sample", sd_n, 0);
        end

        // Majority vote at P=8.
        run_bit(8, 3'b000, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("vote000_bit", int'(Sampled_Bit), 0);
        chk("vote000_pulse_tick", sd_at, 5);
        chk("vote000_pulse_count", sd_n, 1);
        run_bit(8, 3'b010, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("vote010_bit", int'(Sampled_Bit), 0);
        run_bit(8, 3'b101, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("vote101_bit", int'(Sampled_Bit), 1);
        chk("vote101_pulse_tick", sd_at, 5);

        // Illegal ratio falls back to P=8.
        run_bit(5, 3'b100, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("pre5_done_mask", int'(dm), 32'h80);
        chk("pre5_pulse_tick", sd_at, 5);
        chk("pre5_bit", int'(Sampled_Bit), 0);

        // P=32 sampling sits at ticks 14..16, pulse at 17.
        run_bit(32, 3'b011, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("p32_done_mask", int'(dm), 32'h8000_0000);
        chk("p32_pulse_tick", sd_at, 17);
        chk("p32_bit", int'(Sampled_Bit), 1);
        run_bit(32, 3'b001, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("p32_bit0", int'(Sampled_Bit), 0);

        // Bit counter over a full byte at P=16.
        for (int b = 0; b < 8; b++) begin
            run_bit(16, 3'b111, 1'b0, 1'b1, dm, sd_at, sd_n);
            chk("p16_done_mask", int'(dm), 32'h8000);
            chk("p16_bit_counter", int'(Bit_Counter), (b + 1) % 8);
        end
        Bit_EN_CNT = 1'b1;
        Prescale = 6'd8;
        step();
        Bit_EN_CNT = 1'b0;
        step();
        chk("bit_en_drop", int'(Bit_Counter), 0);
        Edge_EN_CNT = 1'b0;
        step();

        // Prescale cut from 32 to 16 past the new wrap point.
        Prescale = 6'd32;
        Edge_EN_CNT = 1'b1;
        repeat (20) step();
        Prescale = 6'd16;
        @(negedge CLK);
        chk("shrink_edge_count", int'(Edge_Count), 20);
        chk("shrink_done", int'(Done), 1);
        step();
        chk("shrink_wrap", int'(Edge_Count), 0);

        // Enable dropped mid-bit, then reset mid-bit.
        Prescale = 6'd8;
        Data_Sample_EN = 1'b1;
        RX_IN = 1'b1;
        repeat (3) step();
        chk("drop_at3", int'(Edge_Count), 3);
        Edge_EN_CNT = 1'b0;
        step();
        chk("drop_next_ec", int'(Edge_Count), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (Sampling_done) pulses++;
            step();
        end
        chk("drop_no_pulse", pulses, 0);
        chk("drop_bit_held", int'(Sampled_Bit), 0);
        Edge_EN_CNT = 1'b1;
        RX_IN = 1'b0;
        repeat (6) step();
        chk("pre_rst_ec", int'(Edge_Count), 6);
        chk("pre_rst_bit", int'(Sampled_Bit), 0);
        RST = 1'b0;
        #1;
        chk("mid_rst_edge_count", int'(Edge_Count), 0);
        chk("mid_rst_bit_counter", int'(Bit_Counter), 0);
        chk("mid_rst_sampled_bit", int'(Sampled_Bit), 1);
        chk("mid_rst_sampling_done", int'(Sampling_done), 0);
        Edge_EN_CNT = 1'b0;
        RX_IN = 1'b1;
        step();
        RST = 1'b1;
        run_bit(8, 3'b000, 1'b1, 1'b0, dm, sd_at, sd_n);
        chk("post_rst_pulse_tick", sd_at, 5);
        chk("post_rst_bit", int'(Sampled_Bit), 0);
        chk("post_rst_done_mask", int'(dm), 32'h80);

        Edge_EN_CNT = 1'b0;
        Data_Sample_EN = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
